// File: rtl/param_stack_cpu.sv
// param_stack_cpu: parametrised stack-machine core with start/halt control and fault detection.
// One instruction per clock from a combinational instruction memory onto a register-file stack.
module param_stack_cpu #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int PC_W   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  output logic [PC_W-1:0]            o_instr_addr,
  input  logic [31:0]                i_instr_data,
  output logic [DATA_W-1:0]          o_top,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_zero,
  output logic                       o_running,
  output logic                       o_halted,
  output logic                       o_error
);
  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;
  state_t            r_state, w_state_nx;
  logic [DATA_W-1:0] r_stk [DEPTH];
  logic [DW-1:0]     r_depth, w_depth_nx;
  logic [PC_W-1:0]   r_pc, w_pc_nx;
  logic              r_zero, w_zero_nx;
  logic [5:0]        w_op;
  logic [DATA_W-1:0] w_imm, w_t, w_s, w_res, w_dat_a, w_dat_b;
  logic [PC_W-1:0]   w_tgt;
  logic [AW-1:0]     w_ti, w_si, w_pi, w_idx_a, w_idx_b;
  logic              w_empty, w_lt2, w_full, w_we_a, w_we_b, w_fault;
  assign w_op    = i_instr_data[31:26];
  assign w_imm   = DATA_W'(i_instr_data[15:0]);
  assign w_tgt   = i_instr_data[PC_W-1:0];
  assign w_ti    = AW'(r_depth - 1'b1);
  assign w_si    = AW'(r_depth - 2'd2);
  assign w_pi    = AW'(r_depth);
  assign w_empty = r_depth == '0;
  assign w_lt2   = r_depth < DW'(2);
  assign w_full  = r_depth == DW'(DEPTH);
  assign w_t     = w_empty ? '0 : r_stk[w_ti];
  assign w_s     = r_stk[w_si];
  assign w_res   = w_op == 6'd3 ? w_s + w_t :
                   w_op == 6'd4 ? w_s | w_t :
                   w_op == 6'd5 ? w_s - w_t :
                   w_op == 6'd6 ? DATA_W'($signed(w_s) < $signed(w_t)) :
                   w_op == 6'd7 ? ~(w_s | w_t) : w_s & w_t;
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_depth_nx = r_depth;
    w_zero_nx  = r_zero;
    w_we_a     = 1'b0;
    w_idx_a    = w_si;
    w_dat_a    = w_res;
    w_we_b     = 1'b0;
    w_idx_b    = w_si;
    w_dat_b    = w_t;
    w_fault    = 1'b0;
    case (r_state)
      S_IDLE: w_state_nx = i_start ? S_RUN : S_IDLE;
      S_RUN: begin
        w_pc_nx = r_pc + 1'b1;
        case (w_op)
          6'd0: ;
          6'd1: begin
            w_fault    = w_full;
            w_we_a     = 1'b1;
            w_idx_a    = w_pi;
            w_dat_a    = w_imm;
            w_depth_nx = r_depth + 1'b1;
          end
          6'd2: begin
            w_fault    = w_empty;
            w_depth_nx = r_depth - 1'b1;
          end
          6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8: begin
            w_fault    = w_lt2;
            w_we_a     = 1'b1;
            w_depth_nx = r_depth - 1'b1;
            w_zero_nx  = w_res == '0;
          end
          6'd9: begin
            w_fault    = w_empty | w_full;
            w_we_a     = 1'b1;
            w_idx_a    = w_pi;
            w_dat_a    = w_t;
            w_depth_nx = r_depth + 1'b1;
          end
          6'd10: begin
            w_fault = w_lt2;
            w_we_a  = 1'b1;
            w_idx_a = w_ti;
            w_dat_a = w_s;
            w_we_b  = 1'b1;
          end
          6'd11: begin
            w_fault    = w_empty;
            w_depth_nx = r_depth - 1'b1;
            w_pc_nx    = w_t == '0 ? w_tgt : r_pc + 1'b1;
          end
          6'd12: w_pc_nx = w_tgt;
          6'd63: begin
            w_pc_nx    = r_pc;
            w_state_nx = S_HALT;
          end
          default: w_fault = 1'b1;
        endcase
        // a faulting instruction leaves all architectural state untouched
        if (w_fault) begin
          w_state_nx = S_FAULT;
          w_pc_nx    = r_pc;
          w_depth_nx = r_depth;
          w_zero_nx  = r_zero;
          w_we_a     = 1'b0;
          w_we_b     = 1'b0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_depth <= '0;
      r_zero  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_depth <= w_depth_nx;
      r_zero  <= w_zero_nx;
      if (w_we_a) r_stk[w_idx_a] <= w_dat_a;
      if (w_we_b) r_stk[w_idx_b] <= w_dat_b;
    end
  end
  assign o_instr_addr = r_pc;
  assign o_top        = w_t;
  assign o_depth      = r_depth;
  assign o_zero       = r_zero;
  assign o_running    = r_state == S_RUN;
  assign o_halted     = r_state == S_HALT;
  assign o_error      = r_state == S_FAULT;
endmodule

// File: tb/tb_param_stack_cpu.sv
// tb_param_stack_cpu: directed program vectors for param_stack_cpu (DEPTH=4 core)
// plus a narrow-PC instance running NOPs to observe address wrap.
module tb_param_stack_cpu;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] mem [256];
  logic [7:0]  addr;
  logic [31:0] top;
  logic [2:0]  depth;
  logic        zero, running, halted, error;
  logic [3:0]  w_addr;
  logic [15:0] w_top;
  logic [1:0]  w_depth;
  logic        w_zero, w_running, w_halted, w_error;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  param_stack_cpu #(.DATA_W(32), .DEPTH(4), .PC_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_instr_addr(addr),
    .i_instr_data(mem[addr]), .o_top(top), .o_depth(depth), .o_zero(zero),
    .o_running(running), .o_halted(halted), .o_error(error));

  param_stack_cpu #(.DATA_W(16), .DEPTH(2), .PC_W(4)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_instr_addr(w_addr),
    .i_instr_data(32'd0), .o_top(w_top), .o_depth(w_depth), .o_zero(w_zero),
    .o_running(w_running), .o_halted(w_halted), .o_error(w_error));

  typedef struct {
    string       name;
    int          base, len, cyc;
    logic [31:0] top;
    int          depth;
    bit          zero;
    int          st;
    int          pc;
  } vec_t;
  vec_t        vecs[$];
  logic [31:0] rom[$];
  int          vbase = 0;

  function automatic logic [31:0] ins(input int op, input int arg);
    return {op[5:0], 10'd0, arg[15:0]};
  endfunction

  task automatic add(input string n, input int cyc, input logic [31:0] t, input int d,
                     input bit z, input int st, input int pc);
    vecs.push_back('{n, vbase, rom.size() - vbase, cyc, t, d, z, st, pc});
    vbase = rom.size();
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int len);
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < len; i++) mem[i] = rom[base + i];
  endtask

  task automatic run_start();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int loops;
    // 0 arith
    rom.push_back(ins(1,5)); rom.push_back(ins(1,3)); rom.push_back(ins(5,0));
    rom.push_back(ins(1,2)); rom.push_back(ins(6,0)); rom.push_back(ins(63,0));
    add("arith", 8, 0, 1, 1, 1, 5);
    // 1 branch loop
    rom.push_back(ins(1,3)); rom.push_back(ins(1,1)); rom.push_back(ins(5,0));
    rom.push_back(ins(9,0)); rom.push_back(ins(11,6)); rom.push_back(ins(12,1));
    rom.push_back(ins(63,0));
    add("loop", 20, 0, 1, 1, 1, 6);
    // 2 overflow
    for (int i = 1; i <= 5; i++) rom.push_back(ins(1,i));
    add("overflow", 6, 4, 4, 0, 2, 4);
    // 3 underflow
    rom.push_back(ins(1,7)); rom.push_back(ins(3,0));
    add("underflow", 4, 7, 1, 0, 2, 1);
    // 4 illegal
    rom.push_back(ins(32,0));
    add("illegal", 3, 0, 0, 0, 2, 0);
    // 5 pop empty
    rom.push_back(ins(2,0));
    add("pop_empty", 3, 0, 0, 0, 2, 0);
    // 6 swap then sub: 20-10
    rom.push_back(ins(1,10)); rom.push_back(ins(1,20)); rom.push_back(ins(10,0));
    rom.push_back(ins(5,0)); rom.push_back(ins(63,0));
    add("swap", 7, 10, 1, 0, 1, 4);
    // 7 or/and
    rom.push_back(ins(1,16'h00f0)); rom.push_back(ins(1,16'h0f0f)); rom.push_back(ins(4,0));
    rom.push_back(ins(1,16'h00ff)); rom.push_back(ins(8,0)); rom.push_back(ins(0,0));
    rom.push_back(ins(63,0));
    add("or_and", 9, 32'h00ff, 1, 0, 1, 6);
    // 8 nor then add wraps
    rom.push_back(ins(1,0)); rom.push_back(ins(1,0)); rom.push_back(ins(7,0));
    rom.push_back(ins(1,16'hffff)); rom.push_back(ins(3,0)); rom.push_back(ins(63,0));
    add("nor_add", 8, 32'h0000fffe, 1, 0, 1, 5);
    // 9 signed slt: -1 < 1
    rom.push_back(ins(1,0)); rom.push_back(ins(1,0)); rom.push_back(ins(7,0));
    rom.push_back(ins(1,1)); rom.push_back(ins(6,0)); rom.push_back(ins(63,0));
    add("slt_signed", 8, 1, 1, 0, 1, 5);
    // 10 dup overflow
    rom.push_back(ins(1,1));
    for (int i = 0; i < 4; i++) rom.push_back(ins(9,0));
    add("dup_overflow", 7, 1, 4, 0, 2, 4);
    // 11 jz empty
    rom.push_back(ins(11,3));
    add("jz_empty", 3, 0, 0, 0, 2, 0);
    // 12 zero result then held by nop
    rom.push_back(ins(1,0)); rom.push_back(ins(1,0)); rom.push_back(ins(3,0));
    rom.push_back(ins(0,0)); rom.push_back(ins(63,0));
    add("zero_hold", 7, 0, 1, 1, 1, 4);
    // 13 jmp skip
    rom.push_back(ins(12,3)); rom.push_back(ins(1,9)); rom.push_back(ins(63,0));
    rom.push_back(ins(1,4)); rom.push_back(ins(63,0));
    add("jmp", 5, 4, 1, 0, 1, 4);

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    step(1);
    chk("rst_top", top, 0);
    chk("rst_depth", depth, 0);
    chk("rst_flags", {zero, running, halted, error}, 0);
    chk("rst_addr", addr, 0);

    foreach (vecs[k]) begin
      load(vecs[k].base, vecs[k].len);
      run_start();
      step(vecs[k].cyc);
      chk({vecs[k].name, "_top"}, top, vecs[k].top);
      chk({vecs[k].name, "_depth"}, depth, vecs[k].depth);
      chk({vecs[k].name, "_zero"}, zero, vecs[k].zero);
      chk({vecs[k].name, "_state"}, {running, halted, error},
          {vecs[k].st == 0, vecs[k].st == 1, vecs[k].st == 2});
      chk({vecs[k].name, "_pc"}, addr, vecs[k].pc);
    end

    // start-up timing and intermediate arithmetic results
    load(vecs[0].base, vecs[0].len);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1);
    chk("idle_running", running, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("start_running", running, 1);
    chk("start_pc", addr, 0);
    step(1);
    chk("first_exec_top", top, 5);
    chk("first_exec_pc", addr, 1);
    step(2);
    chk("after_sub_top", top, 2);
    chk("after_sub_zero", zero, 0);
    step(2);
    chk("after_slt_top", top, 0);
    chk("after_slt_zero", zero, 1);

    // async reset mid-run aborts everything at once
    load(vecs[1].base, vecs[1].len);
    run_start();
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {top, 5'(depth), zero, running, halted, error, addr}, 0);
    chk("async_rst_wrap", {w_addr, w_running}, 0);

    // loop body count, with start pulses in RUN ignored
    run_start();
    loops = 0;
    for (int c = 0; c < 40 && !halted; c++) begin
      if (addr == 8'd2) loops++;
      start = (c == 3);
      step(1);
    end
    start = 1'b0;
    chk("loop_iterations", loops, 3);
    chk("loop_halted", {halted, addr}, {1'b1, 8'd6});
    step(3);
    chk("halt_holds_pc", addr, 6);

    // start pulses in FAULT do nothing
    load(vecs[4].base, vecs[4].len);
    run_start();
    step(2);
    start = 1'b1;
    step(2);
    start = 1'b0;
    step(1);
    chk("fault_sticky", {error, running, addr}, {1'b1, 1'b0, 8'd0});

    // start pulses in HALT do nothing
    load(vecs[0].base, vecs[0].len);
    run_start();
    step(8);
    start = 1'b1;
    step(2);
    start = 1'b0;
    chk("halt_sticky", {halted, running, addr}, {1'b1, 1'b0, 8'd5});

    // PC wrap on the 4-bit instance
    run_start();
    step(15);
    chk("wrap_pc15", w_addr, 15);
    step(1);
    chk("wrap_pc0", w_addr, 0);
    step(1);
    chk("wrap_continue", {w_addr, w_running, w_error}, {4'd1, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_stack_cpu.md
# param_stack_cpu

Parametrised stack-machine core. It fetches 32-bit instructions from an external combinational instruction memory and executes one instruction per clock on an internal register-file stack of configurable width and depth. It adds start/halt control, conditional and unconditional branches, DUP/SWAP, and overflow, underflow and illegal-opcode fault detection. It replaces the fixed 32-bit free-running stack CPU as the top-level compute core and keeps the same opcode numbering for the shared operations.

## Interface
- DATA_W, 32, datapath and stack entry width; legal range 16..64.
- DEPTH, 16, number of stack entries; legal range 2..256.
- PC_W, 8, instruction address width; the PC wraps modulo 2^PC_W.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to leave IDLE and begin execution at address 0.
- instr_addr  out  PC_W  current PC, driven directly from the PC register.
- instr_data  in  32  instruction at instr_addr, valid in the same cycle (combinational memory).
- top  out  DATA_W  entry at top of stack; 0 when the stack is empty.
- depth  out  $clog2(DEPTH+1)  number of valid stack entries.
- zero  out  1  1 when the most recent ALU result was 0.
- running  out  1  state == RUN.
- halted  out  1  state == HALT.
- error  out  1  state == FAULT.

## Operation
- Opcode is instr_data[31:26]. imm is instr_data[15:0], zero-extended to DATA_W. tgt is instr_data[PC_W-1:0]. T is the top entry and S is the entry below it.
- 0 NOP: no stack change.
- 1 PUSH: push imm.
- 2 POP: discard T.
- 3 ADD: S+T.
- 4 OR: S|T.
- 5 SUB: S−T.
- 6 SLT: 1 if S<T as signed values, else 0.
- 7 NOR: ~(S|T).
- 8 AND: S&T.
- Binary ops (3–8) pop two entries and push the result, so depth decreases by 1. The result wraps modulo 2^DATA_W and carry is discarded.
- 9 DUP: push T.
- 10 SWAP: exchange T and S.
- 11 JZ: pop T. If T==0, PC←tgt; otherwise PC←PC+1.
- 12 JMP: PC←tgt.
- 63 HALT: enter HALT.
- All other opcodes are illegal and cause FAULT.
- All instructions other than JZ, JMP and HALT set PC←PC+1.
- zero is updated only by binary ops (result==0). It holds its value otherwise.
- State machine:
  - IDLE: start=1 → RUN.
  - RUN: HALT → HALT; any fault → FAULT; otherwise stay in RUN.
  - HALT and FAULT are terminal. Only reset exits them, and start is ignored in both.
- Fault conditions, each checked against the depth before the instruction executes:
  - Underflow: POP, DUP or JZ with depth==0; binary op or SWAP with depth<2.
  - Overflow: PUSH or DUP with depth==DEPTH.
  - Illegal opcode.
- A faulting instruction changes nothing: PC, stack, depth and zero all hold, and only the state moves to FAULT.
- In HALT, PC holds on the HALT instruction's address.

## Timing
- Reset (reset=0) takes effect immediately. It forces state=IDLE, PC=0, depth=0, all stack entries=0 and zero=0, which gives top=0, running=0, halted=0 and error=0.
- Reset asserted in the middle of execution aborts the in-flight instruction, with no partial update.
- Start-up sequence:
  - The edge that samples start=1 in IDLE only changes state; PC stays 0.
  - The first instruction (address 0) executes on the following edge.
- Throughput is one instruction per clock while in RUN. All architectural updates (PC, stack, depth, zero, state) happen on the same rising edge.
- top, depth and zero reflect an instruction on the cycle after the edge that executed it. All outputs are registered or come directly from registers, except top, which is a mux of the stack array indexed by the depth register.
- Wrap-around: PC=2^PC_W−1 followed by a non-branch instruction gives PC=0.
- start pulses while in RUN are ignored.

## Test plan
- Reset and start:
  - Stimulus: hold reset=0, release it, pulse start.
  - Required response: every output is 0 during reset; running=1 one cycle after start; instr_addr=0 on the first execute edge.
- Arithmetic:
  - Program: PUSH 5, PUSH 3, SUB, PUSH 2, SLT, HALT.
  - Required response: top=2 after SUB, then top=0 after SLT (2<2 is false); depth=1; zero=1; halted=1 with instr_addr=5.
- Branch loop:
  - Program: PUSH 3; at address 1: PUSH 1, SUB, DUP, JZ 6, JMP 1; address 6: HALT.
  - Required response: the loop body runs 3 times; the run ends halted with depth=1, top=0, instr_addr=6.
- Overflow:
  - Stimulus: DEPTH=4, five PUSHes.
  - Required response: error=1 after the 5th PUSH edge; depth=4; top keeps the 4th value; PC holds at 4.
- Underflow and illegal opcode:
  - Stimulus (run 1): PUSH 7, ADD. Stimulus (run 2): opcode 0x20.
  - Required response: each run gives error=1 with stack and PC unchanged; start pulses afterwards have no effect.
- PC wrap:
  - Stimulus: PC_W=4, 16 NOPs.
  - Required response: instr_addr goes 15 → 0 and execution continues.
